// File: rtl/conv_result_streamer_pkg.sv
// Shared types, sizes and the result-length helper for the convolution result drain path.
package conv_pkg;

  localparam int CONV_DATA_WIDTH = 32;
  localparam int CONV_ADDR_WIDTH = 5;
  localparam int Z_ADDR_WIDTH    = CONV_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, FIN} stream_state_t;

  // Full linear convolution length; an empty operand yields an empty result.
  function automatic logic [Z_ADDR_WIDTH-1:0] conv_len(
    input logic [CONV_ADDR_WIDTH-1:0] size_x,
    input logic [CONV_ADDR_WIDTH-1:0] size_y
  );
    if (size_x == '0 || size_y == '0) return '0;
    return Z_ADDR_WIDTH'(size_x) + Z_ADDR_WIDTH'(size_y) - Z_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/conv_result_streamer_if.sv
// Valid/ready output word stream toward the bus/host side.
interface conv_result_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/conv_result_streamer_fifo.sv
// Two-entry result buffer between the memZ read port and the word serializer.
module conv_stream_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  // The read-credit logic upstream must make these impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == 2'd2));
  assert property (@(posedge clk) disable iff (rst) !(pop && count == 2'd0));

endmodule

// File: rtl/conv_result_streamer.sv
// Drains N = sizeX+sizeY-1 memZ results after the core finishes, low word then high word per entry.
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int ADDR_WIDTH = CONV_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     config_in,
  output logic [ADDR_WIDTH:0]       memZ_addr,
  input  logic [2*DATA_WIDTH-1:0]   memZ_data,
  conv_result_streamer_if.master    stream,
  output logic                      busy,
  output logic                      done
);

  localparam int ZW = ADDR_WIDTH + 1;

  stream_state_t           state;
  stream_state_t           state_nxt;
  logic [ZW-1:0]           n_len;
  logic [ZW-1:0]           cfg_len;
  logic [ZW-1:0]           rd_addr;
  logic [ZW-1:0]           last_addr;
  logic [ZW-1:0]           pop_idx;
  logic                    in_flight;
  logic                    sel;
  logic [1:0]              fifo_count;
  logic [2*DATA_WIDTH-1:0] head;
  logic                    issue;
  logic                    hs;
  logic                    pop;
  logic                    is_last;
  logic                    start_ok;
  logic                    unused_cfg;

  assign unused_cfg = ^config_in[DATA_WIDTH-1:2*ADDR_WIDTH];
  assign cfg_len    = conv_len(config_in[ADDR_WIDTH-1:0], config_in[2*ADDR_WIDTH-1:ADDR_WIDTH]);
  assign start_ok   = start && (state == IDLE);

  // A read may only go out if its data is guaranteed a FIFO slot on return.
  assign issue   = (state == STREAM) && (rd_addr < n_len)
                && (({1'b0, fifo_count} + {2'b00, in_flight}) < 3'd2);
  assign hs      = stream.valid && stream.ready;
  assign pop     = hs && sel;
  assign is_last = sel && (pop_idx == n_len - ZW'(1));

  assign memZ_addr = issue ? rd_addr : last_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_len == '0) ? FIN : STREAM;
      STREAM:  if (hs && is_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == STREAM);
  assign done = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_len     <= '0;
      rd_addr   <= '0;
      last_addr <= '0;
      pop_idx   <= '0;
      in_flight <= 1'b0;
      sel       <= 1'b0;
    end else begin
      in_flight <= issue;
      if (start_ok) begin
        n_len   <= cfg_len;
        rd_addr <= '0;
        pop_idx <= '0;
        sel     <= 1'b0;
      end else begin
        if (issue) begin
          rd_addr   <= rd_addr + ZW'(1);
          last_addr <= rd_addr;
        end
        if (hs) begin
          sel <= ~sel;
          if (sel) pop_idx <= pop_idx + ZW'(1);
        end
      end
    end
  end

  // Read data lands one cycle after issue, so the in-flight flag doubles as the push strobe.
  conv_stream_fifo #(.WIDTH(2*DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_flight),
    .pop   (pop),
    .din   (memZ_data),
    .head  (head),
    .count (fifo_count)
  );

  assign stream.valid = (fifo_count != 2'd0);
  assign stream.data  = sel ? head[2*DATA_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
  assign stream.last  = is_last;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomized bench for conv_result_streamer against a queue-based model of the drained word sequence.
`timescale 1ns/1ps
module tb_conv_result_streamer;
  import conv_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DW-1:0]     config_in = '0;
  logic [AW:0]       memZ_addr;
  logic [2*DW-1:0]   memZ_data;
  logic              busy;
  logic              done;

  conv_result_streamer_if #(.DATA_WIDTH(DW)) stream ();

  conv_result_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .config_in (config_in),
    .memZ_addr (memZ_addr),
    .memZ_data (memZ_data),
    .stream    (stream),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // memZ: one-cycle synchronous read
  logic [2*DW-1:0] mem [64];
  always @(posedge clk) memZ_data <= mem[memZ_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  bit            mon_en = 0;
  logic [DW-1:0] got_q [$];
  bit            last_q [$];
  int            exp_words, first_valid, last_hs, done_cnt, done_cyc, busy_cnt;
  int            bubbles, max_addr, fifo_max, start_cyc;
  bit            stall_prev, prev_last;
  logic [DW-1:0] prev_data;

  task automatic arm_monitor(input int n);
    got_q.delete();
    last_q.delete();
    exp_words   = 2 * n;
    first_valid = -1;
    last_hs     = -1;
    done_cnt    = 0;
    done_cyc    = -1;
    busy_cnt    = 0;
    bubbles     = 0;
    max_addr    = -1;
    fifo_max    = 0;
    stall_prev  = 0;
    mon_en      = 1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_valid", stream.valid, 1'b1);
        chk("hold_data", stream.data, prev_data);
        chk("hold_last", stream.last, prev_last);
      end
      stall_prev = stream.valid && !stream.ready;
      prev_data  = stream.data;
      prev_last  = stream.last;
      if (stream.valid && first_valid < 0) first_valid = cyc;
      if (!stream.valid && first_valid >= 0 && got_q.size() < exp_words) bubbles++;
      if (stream.valid && stream.ready) begin
        got_q.push_back(stream.data);
        last_q.push_back(stream.last);
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) begin
        busy_cnt++;
        if (int'(memZ_addr) > max_addr) max_addr = int'(memZ_addr);
      end
      if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);
    end
  end

  function automatic int model_len(input int sx, input int sy);
    return (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
  endfunction

  function automatic bit draw_ready(input int pct);
    return (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
  endfunction

  task automatic preload_pattern();
    for (int i = 0; i < 64; i++) mem[i] = {32'(i + 100), 32'(i)};
  endtask

  task automatic preload_random();
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic pulse_start(input int sx, input int sy, input int pct);
    @(posedge clk); #1;
    config_in         = '0;
    config_in[AW-1:0] = AW'(sx);
    config_in[2*AW-1:AW] = AW'(sy);
    start        = 1'b1;
    start_cyc    = cyc;
    stream.ready = draw_ready(pct);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one drain and compares everything observed against the model.
  task automatic do_drain(input int sx, input int sy, input int pct, input int inject_at, input bit flow);
    int n;
    int budget;
    n = model_len(sx, sy);
    arm_monitor(n);
    pulse_start(sx, sy, pct);
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      if (budget == inject_at) begin
        config_in         = '0;
        config_in[AW-1:0] = AW'(3);
        config_in[2*AW-1:AW] = AW'(2);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      stream.ready = draw_ready(pct);
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    chk($sformatf("done_seen_%0dx%0d", sx, sy), budget < 3000, 1'b1);
    repeat (4) begin
      stream.ready = draw_ready(pct);
      @(posedge clk); #1;
    end
    mon_en = 0;

    chk($sformatf("word_count_%0dx%0d", sx, sy), got_q.size(), exp_words);
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < 2; h++) begin
        int idx;
        idx = 2 * i + h;
        if (idx < got_q.size()) begin
          chk($sformatf("word_%0d", idx), got_q[idx], h ? mem[i][2*DW-1:DW] : mem[i][DW-1:0]);
          chk($sformatf("last_%0d", idx), last_q[idx], (i == n - 1) && (h == 1));
        end
      end
    end
    chk("done_count", done_cnt, 1);
    if (n > 0) begin
      chk("done_after_last", done_cyc, last_hs + 1);
      chk("busy_cycles", busy_cnt, last_hs - start_cyc);
      chk("max_addr", max_addr, n - 1);
      chk("fifo_bound", fifo_max <= 2, 1'b1);
      if (flow) begin
        chk("first_valid", first_valid, start_cyc + 3);
        chk("bubbles", bubbles, 0);
      end
    end else begin
      chk("no_valid", first_valid, -1);
      chk("busy_empty", busy_cnt, 0);
      chk("done_after_start", done_cyc, start_cyc + 1);
    end
  endtask

  initial begin
    int budget;
    stream.ready = 1'b0;
    preload_pattern();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", stream.valid, 1'b0);
    chk("rst_last", stream.last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", memZ_addr, '0);
    rst = 1'b0;

    do_drain(10, 5, 100, -1, 1'b1);
    do_drain(10, 5, 30, -1, 1'b0);
    do_drain(0, 7, 100, -1, 1'b1);
    do_drain(31, 31, 100, -1, 1'b1);
    do_drain(10, 5, 100, 6, 1'b1);

    // Abort mid-stream with an asynchronous reset
    arm_monitor(14);
    pulse_start(10, 5, 100);
    budget = 0;
    while (got_q.size() < 9 && budget < 200) begin
      stream.ready = 1'b1;
      @(posedge clk); #1;
      budget++;
    end
    chk("reached_9_words", got_q.size(), 9);
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk("abort_valid", stream.valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_drain(3, 2, 100, -1, 1'b1);

    // Random contents, sizes and backpressure
    for (int t = 0; t < 4; t++) begin
      preload_random();
      do_drain($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(40, 90), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
